// File: rtl/clkmux_sel_ctrl.sv
// clkmux_sel_ctrl: sequences the 2-bit select of the 4:1 glitch-less clock mux.
// The muxed domain is held in reset around each select change.
// If the selected clock dies, the block falls back to source 0 on its own.
module clkmux_sel_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  input  logic [3:0] clk_ok,
  output logic [1:0] sel,
  output logic       dom_rst_req,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       fallback
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    SWITCH  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      target_q, target_d;
  logic [1:0]      sel_q, sel_d;
  logic            dom_q, dom_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            fb_q, fb_d;
  logic            fb_cond;
  logic            accept;

  assign fb_cond   = !clk_ok[sel_q] && (sel_q != 2'd0);
  assign req_ready = (state_q == IDLE) && !fb_cond && !rst;
  assign accept    = req_valid && req_ready;

  // Next-state and next-output decode; outputs follow the state being entered
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    fb_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fb_cond) begin
          target_d = 2'd0;
          fb_d     = 1'b1;
          cnt_d    = HOLD_LD;
          state_d  = HOLD;
        end else if (accept) begin
          if (req_sel == sel_q) begin
            done_d = 1'b1;
          end else if (!clk_ok[req_sel]) begin
            err_d = 1'b1;
          end else begin
            target_d = req_sel;
            cnt_d    = HOLD_LD;
            state_d  = HOLD;
          end
        end
      end

      HOLD: begin
        // A dead target aborts before the select is ever touched
        if (!clk_ok[target_q]) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (cnt_q == '0) begin
          sel_d   = target_q;
          cnt_d   = SETTLE_LD;
          state_d = SWITCH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      SWITCH: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    dom_d  = (state_d == HOLD) || (state_d == SWITCH);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; synchronous reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      sel_q    <= '0;
      dom_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      dom_q    <= dom_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fb_q     <= fb_d;
    end
  end

  assign sel         = sel_q;
  assign dom_rst_req = dom_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign fallback    = fb_q;

endmodule
